// File: rtl/health_controller.sv
// rtl/health_controller.sv - player health state, damage arbitration and health bar sequencing
//
// One round-robin grant per frame start. A grant lands as damage only while the
// player is vulnerable; otherwise it is acked and dropped. The frame on which the
// invulnerability counter expires is itself vulnerable, so consecutive damaging
// hits are exactly IFRAMES frames apart.

module health_controller #(
  parameter int NUM_SRC    = 4,
  parameter int MAX_HEALTH = 24,
  parameter int IFRAMES    = 60,
  parameter int HW         = $clog2(MAX_HEALTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [NUM_SRC-1:0] dmg_req,
  input  logic               restart_in,
  output logic [NUM_SRC-1:0] dmg_ack,
  output logic               damage_out,
  output logic               bar_rst_out,
  output logic [HW-1:0]      health_out,
  output logic               invuln_out,
  output logic               game_over
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam logic [HW-1:0] HEALTH_MAX = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] HEALTH_ONE = HW'(1);
  localparam logic [7:0]    INV_LOAD   = 8'(IFRAMES);
  localparam logic [PW-1:0] LAST_SRC   = PW'(NUM_SRC - 1);
  localparam logic [PW:0]   NSRC_W     = (PW + 1)'(NUM_SRC);

  logic [1:0]         state_q,   state_d;
  logic [HW-1:0]      health_q,  health_d;
  logic [7:0]         inv_cnt_q, inv_cnt_d;
  logic [PW-1:0]      rr_ptr_q,  rr_ptr_d;
  logic [NUM_SRC-1:0] ack_q,     ack_d;
  logic               bar_rst_q, bar_rst_d;

  logic               fs;
  logic               can_hit;
  logic               grant_valid;
  logic [PW-1:0]      grant_idx;
  logic [PW:0]        cand;

  assign fs = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Vulnerable in ALIVE, and in INVULN on the frame where the window runs out
  assign can_hit = (health_q != '0) &&
                   ((state_q == ST_ALIVE) ||
                    ((state_q == ST_INVULN) && (inv_cnt_q == 8'd1)));

  assign damage_out = fs && can_hit && (|dmg_req);

  // Round-robin search: first asserted request at or above rr_ptr, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW + 1)'(i);
      if (cand >= NSRC_W) cand = cand - NSRC_W;
      if (!grant_valid && dmg_req[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  // Next-state: grant bookkeeping, then health/state update, restart overrides last
  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    inv_cnt_d = inv_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    bar_rst_d = 1'b0;

    if (fs && grant_valid) begin
      ack_d[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == LAST_SRC) ? '0 : grant_idx + PW'(1);
    end

    case (state_q)
      ST_ALIVE, ST_INVULN: begin
        if (fs && (state_q == ST_INVULN)) begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          if (inv_cnt_q == 8'd1) state_d = ST_ALIVE;
        end
        if (damage_out) begin
          health_d = health_q - HEALTH_ONE;
          if (health_q == HEALTH_ONE) begin
            state_d   = ST_DEAD;
            inv_cnt_d = '0;
          end else begin
            state_d   = ST_INVULN;
            inv_cnt_d = INV_LOAD;
          end
        end
      end
      ST_DEAD: begin
        if (restart_in) begin
          state_d   = ST_ALIVE;
          health_d  = HEALTH_MAX;
          rr_ptr_d  = '0;
          inv_cnt_d = '0;
          bar_rst_d = 1'b1;
        end
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ALIVE;
      health_q  <= HEALTH_MAX;
      inv_cnt_q <= '0;
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      bar_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      inv_cnt_q <= inv_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      bar_rst_q <= bar_rst_d;
    end
  end

  assign dmg_ack     = ack_q;
  assign bar_rst_out = bar_rst_q;
  assign health_out  = health_q;
  assign invuln_out  = (state_q == ST_INVULN);
  assign game_over   = (state_q == ST_DEAD);

endmodule

// File: tb/tb_health_controller.sv
// tb/tb_health_controller.sv - scoreboard bench for health_controller

module tb_health_controller;

  localparam int NS  = 4;
  localparam int MH  = 5;
  localparam int IFR = 3;
  localparam int HWL = $clog2(MH + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [10:0]    hcount_in;
  logic [9:0]     vcount_in;
  logic [NS-1:0]  dmg_req;
  logic           restart_in;
  logic [NS-1:0]  dmg_ack;
  logic           damage_out;
  logic           bar_rst_out;
  logic [HWL-1:0] health_out;
  logic           invuln_out;
  logic           game_over;

  always #5 clk = ~clk;

  health_controller #(
    .NUM_SRC(NS), .MAX_HEALTH(MH), .IFRAMES(IFR)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .dmg_req(dmg_req), .restart_in(restart_in),
    .dmg_ack(dmg_ack), .damage_out(damage_out), .bar_rst_out(bar_rst_out),
    .health_out(health_out), .invuln_out(invuln_out), .game_over(game_over)
  );

  typedef struct {
    logic [NS-1:0] ack;
    int            health;
    bit            inv;
    bit            go;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: game-level view in frames and hit timestamps
  int m_health, m_frame, m_last_hit, m_rr;
  bit m_dead, m_hit_ever, pend_bar;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_health   = MH;
    m_dead     = 1'b0;
    m_hit_ever = 1'b0;
    m_rr       = 0;
  endfunction

  function automatic bit model_shielded();
    return m_hit_ever && ((m_frame - m_last_hit) < IFR);
  endfunction

  task automatic set_blank();
    hcount_in = 11'($urandom_range(0, 3));
    vcount_in = (hcount_in == 11'd0) ? 10'($urandom_range(1, 5)) : 10'($urandom_range(0, 5));
  endtask

  // Monitor: every ack pops one expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && dmg_ack != '0) begin
        if (sb.size() == 0) chk("unexpected_ack", int'(dmg_ack), 0);
        else begin
          e = sb.pop_front();
          chk("dmg_ack", int'(dmg_ack), int'(e.ack));
          chk("health_out", int'(health_out), e.health);
          chk("invuln_out", int'(invuln_out), int'(e.inv));
          chk("game_over", int'(game_over), int'(e.go));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; restart_in = 1'b0; set_blank();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    sb.delete();
    pend_bar = 1'b0;
    @(negedge clk);
    chk("rst_health", int'(health_out), MH);
    chk("rst_invuln", int'(invuln_out), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_dmg_ack", int'(dmg_ack), 0);
    chk("rst_bar_rst", int'(bar_rst_out), 0);
  endtask

  task automatic do_frame(input int raise_pct, input int restart_pct, input bit restart_at_fs);
    bit   any, dmg, was_dead, rs_eff;
    int   g, n;
    exp_t e;
    @(posedge clk); #1;
    hcount_in = 11'd0; vcount_in = 10'd0; restart_in = restart_at_fs;
    any = (dmg_req != '0);
    g = -1;
    for (int k = 0; k < NS; k++)
      if (g < 0 && dmg_req[(m_rr + k) % NS]) g = (m_rr + k) % NS;
    dmg = any && !m_dead && !model_shielded();
    @(negedge clk);
    chk("damage_out_fs", int'(damage_out), int'(dmg));
    chk("bar_rst_out", int'(bar_rst_out), int'(pend_bar));
    was_dead = m_dead;
    if (any) m_rr = (g + 1) % NS;
    if (dmg) begin
      m_health--;
      m_hit_ever = 1'b1;
      m_last_hit = m_frame;
      if (m_health == 0) m_dead = 1'b1;
    end
    rs_eff = was_dead && restart_at_fs;
    if (rs_eff) model_reset();
    pend_bar = rs_eff;
    if (any) begin
      e.ack    = NS'(1) << g;
      e.health = m_health;
      e.inv    = !m_dead && model_shielded();
      e.go     = m_dead;
      sb.push_back(e);
    end
    m_frame++;
    // ack cycle: requester drops the granted line
    @(posedge clk); #1;
    set_blank(); restart_in = 1'b0;
    if (any) dmg_req[g] = 1'b0;
    @(negedge clk);
    chk("damage_out_idle", int'(damage_out), 0);
    chk("bar_rst_out", int'(bar_rst_out), int'(pend_bar));
    pend_bar = 1'b0;
    n = $urandom_range(1, 3);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      set_blank();
      for (int b = 0; b < NS; b++)
        if ($urandom_range(0, 99) < raise_pct) dmg_req[b] = 1'b1;
      restart_in = ($urandom_range(0, 99) < restart_pct);
      @(negedge clk);
      if (c == 0) chk("ack_missing", sb.size(), 0);
      chk("damage_out_idle", int'(damage_out), 0);
      chk("bar_rst_out", int'(bar_rst_out), int'(pend_bar));
      pend_bar = m_dead && restart_in;
      if (pend_bar) model_reset();
    end
  endtask

  initial begin
    rst = 1'b1; dmg_req = '0; restart_in = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd5;
    m_frame = 0; m_last_hit = 0; pend_bar = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // single requester, then continuous requests on all sources
    @(posedge clk); #1; dmg_req = 4'b0001; set_blank();
    do_frame(0, 0, 0);
    repeat (12) do_frame(100, 0, 0);
    for (int i = 0; i < 40 && !m_dead; i++) do_frame(100, 0, 0);
    chk("reached_dead", int'(game_over), 1);
    repeat (2) do_frame(100, 0, 0);
    // restart coinciding with a frame-start grant
    do_frame(100, 0, 1);

    repeat (300) do_frame(40, 15, 0);

    // reset in the middle of an invulnerability window
    for (int i = 0; i < 40; i++) begin
      if (m_dead) do_frame(0, 100, 0);
      else if (m_hit_ever && m_last_hit == m_frame - 1) break;
      else do_frame(100, 0, 0);
    end
    chk("pre_rst_invuln", int'(invuln_out), 1);
    do_reset();
    @(posedge clk); #1; dmg_req[2] = 1'b1; set_blank();
    do_frame(30, 0, 0);
    repeat (5) do_frame(30, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
